// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready core request into APB SETUP/ACCESS
// phases, with a per-transfer ACCESS timeout so a hung peripheral cannot stall the core.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (TO_BITS > 8) ? TO_BITS : 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               abort_pend;

    // Abort fires after TIMEOUT consecutive pready-low ACCESS cycles; 0 disables it.
    logic timeout_hit;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            abort_pend <= 1'b0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwdata     <= '0;
        end else begin
            rsp_valid <= 1'b0;

            // Timeout response is issued one cycle after the bus has been released.
            if (abort_pend) begin
                abort_pend <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_rdata  <= '0;
                rsp_err    <= 1'b1;
                req_ready  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        paddr     <= req_addr;
                        pwrite    <= req_write;
                        pwdata    <= req_wdata;
                        psel      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                    penable  <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (timeout_hit) begin
                        abort_pend <= 1'b1;
                        psel       <= 1'b0;
                        penable    <= 1'b0;
                        state      <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: table of single transfers plus hand-written
// timeout, back-to-back and reset-mid-transfer sequences.
module tb_apb_master_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid, req_write;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [19:0] paddr;
    logic        pwrite, psel, penable;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;

    // Second instance with the timeout disabled; its pready is tied low.
    logic        req_valid0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic [19:0] paddr0;
    logic        pwrite0, psel0, penable0;
    logic [31:0] pwdata0;
    logic        pready0;

    int nvec = 0;
    int nerr = 0;

    apb_master_bridge #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    apb_master_bridge #(.ADDR_W(20), .DATA_W(32), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .paddr(paddr0), .pwrite(pwrite0), .psel(psel0), .penable(penable0), .pwdata(pwdata0),
        .pready(pready0), .prdata(prdata), .pslverr(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [19:0] addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] prdata;
        logic        pslverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer starting in IDLE; checks every phase up to the response and after.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, " req_ready idle"}, 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'hC0FFEE00;
        step();
        req_valid = 1'b0;
        req_addr  = 20'h00000;
        req_wdata = 32'h0;
        chk({tag, " setup sel/en/rdy"}, 64'({psel, penable, req_ready}), 64'(3'b100));
        step();
        chk({tag, " access sel/en"}, 64'({psel, penable}), 64'(2'b11));
        chk({tag, " access paddr"}, 64'(paddr), 64'(v.addr));
        chk({tag, " access pwrite"}, 64'(pwrite), 64'(v.write));
        chk({tag, " access pwdata"}, 64'(pwdata), 64'(v.wdata));
        for (int w = 0; w < int'(v.waits); w++) begin
            step();
            chk({tag, " wait hold"}, 64'({psel, penable, rsp_valid, paddr, pwdata}),
                64'({1'b1, 1'b1, 1'b0, v.addr, v.wdata}));
        end
        pready  = 1'b1;
        prdata  = v.prdata;
        pslverr = v.pslverr;
        step();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        chk({tag, " rsp_valid"}, 64'({rsp_valid, req_ready, psel, penable}), 64'(4'b1100));
        chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
        step();
        chk({tag, " rsp pulse/hold"}, 64'({rsp_valid, rsp_err, rsp_rdata}),
            64'({1'b0, v.exp_err, v.exp_rdata}));
    endtask

    initial begin
        vec_t rv;
        int   cnt0;

        vecs[0] = '{1'b1, 20'h06004, 32'hDEADBEEF, 0, 32'h00000055, 1'b0, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 20'h08010, 32'h00000000, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0};
        vecs[2] = '{1'b0, 20'h0A000, 32'h00000000, 0, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 1'b1};
        vecs[3] = '{1'b1, 20'h1FFFC, 32'h0000FFFF, 2, 32'h77777777, 1'b1, 32'h0,        1'b1};
        vecs[4] = '{1'b0, 20'hFFFFF, 32'h00000000, 1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0;
        pready = 1'b0; pready0 = 1'b0; pslverr = 1'b0; prdata = '0;
        step();
        step();
        chk("reset outputs", 64'({req_ready, rsp_valid, rsp_err, psel, penable, pwrite}),
            64'(6'b100000));
        chk("reset data", 64'({paddr, pwdata} | {20'h0, rsp_rdata}), 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Timeout with TIMEOUT=4; pready pulses in SETUP and in IDLE must be ignored.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h02000;
        step();                                  // N+1 SETUP
        req_valid = 1'b0;
        pready = 1'b1; pslverr = 1'b1;
        step();                                  // N+2 ACCESS
        pready = 1'b0; pslverr = 1'b0;
        chk("to access entered", 64'({psel, penable}), 64'(2'b11));
        step(); step(); step();                  // N+5
        chk("to still waiting", 64'({psel, penable, rsp_valid}), 64'(3'b110));
        step();                                  // N+6
        pready = 1'b1;
        chk("to bus released", 64'({psel, penable, rsp_valid}), 64'(3'b000));
        step();                                  // N+7
        pready = 1'b0;
        chk("to rsp", 64'({rsp_valid, rsp_err, req_ready, rsp_rdata}),
            64'({1'b1, 1'b1, 1'b1, 32'h0}));
        step();
        chk("to rsp pulse", 64'({rsp_valid, psel}), 64'(2'b00));

        // Back-to-back: second request waits in req_valid until the first responds.
        pready = 1'b1; prdata = 32'h0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h04000; req_wdata = 32'h11111111;
        step();                                  // N+1 SETUP A
        req_write = 1'b0; req_addr = 20'h04004; req_wdata = 32'h22222222;
        step();                                  // N+2 ACCESS A
        chk("b2b A access", 64'({penable, pwrite, paddr}), 64'({1'b1, 1'b1, 20'h04000}));
        prdata = 32'h0BADF00D;
        step();                                  // N+3 rsp A, accept B
        chk("b2b A rsp", 64'({rsp_valid, req_ready, rsp_rdata}), 64'({1'b1, 1'b1, 32'h0}));
        step();                                  // N+4 SETUP B
        req_valid = 1'b0;
        chk("b2b B setup", 64'({psel, penable, pwrite, paddr}),
            64'({1'b1, 1'b0, 1'b0, 20'h04004}));
        step();                                  // N+5 ACCESS B
        step();                                  // N+6 rsp B
        chk("b2b B rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'({1'b1, 1'b0, 32'h0BADF00D}));
        pready = 1'b0; prdata = 32'h0;
        step();

        // TIMEOUT=0 instance never aborts.
        req_valid0 = 1'b1; req_write = 1'b0; req_addr = 20'h0C000;
        step();
        req_valid0 = 1'b0;
        cnt0 = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (rsp_valid0) cnt0++;
        end
        chk("no-timeout rsp count", 64'(cnt0), 64'(0));
        chk("no-timeout still access", 64'({psel0, penable0}), 64'(2'b11));

        // Reset while penable=1: async clear, then a clean write.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h0E008; req_wdata = 32'h5A5A5A5A;
        step();
        req_valid = 1'b0;
        step();
        chk("mid access en", 64'(penable), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async reset", 64'({psel, penable, rsp_valid, req_ready}), 64'(4'b0001));
        step(); step();
        rst = 1'b0;
        step();
        chk("post reset quiet", 64'({rsp_valid, psel, paddr}), 64'(0));
        rv = '{1'b1, 20'h0E00C, 32'hCAFEF00D, 1, 32'h99999999, 1'b0, 32'h0, 1'b0};
        run_vec(rv, 9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
